// File: rtl/mux_sweep_pkg.sv
// Shared types and reference function for the mux sweep checker.
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int VEC_W = 3;
  localparam int NUM_VEC = 8;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'b111;

  function automatic logic mux_ref(
    input logic s,
    input logic a,
    input logic b
  );
    return s ? b : a;
  endfunction

endpackage

// File: rtl/mux_sweep_cmp.sv
// Compares DUT outputs with the reference mux value for one vector.
module mux_sweep_cmp
  import mux_sweep_pkg::*;
#(
  parameter int NUM_DUT = 3,
  parameter int CNT_W = $clog2(NUM_DUT + 1)
) (
  input  logic [VEC_W-1:0]   vec,
  input  logic [NUM_DUT-1:0] dut_out,
  output logic [NUM_DUT-1:0] mask,
  output logic [CNT_W-1:0]   cnt
);

  logic exp;

  assign exp = mux_ref(vec[2], vec[1], vec[0]);

  // Case inequality so an unknown output is a mismatch.
  always_comb begin
    mask = '0;
    cnt  = '0;
    for (int i = 0; i < NUM_DUT; i++) begin
      mask[i] = (dut_out[i] !== exp);
      cnt = cnt + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/mux_sweep_checker.sv
// Sweep sequencer driving all 8 mux vectors and checking NUM_DUT outputs.
// Define MUX_SWEEP_STOP_ON_ERR_EN to end the sweep at the first bad vector.
module mux_sweep_checker
  import mux_sweep_pkg::*;
#(
  parameter int NUM_DUT = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               sel,
  output logic               in0,
  output logic               in1,
  input  logic [NUM_DUT-1:0] dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [VEC_W-1:0]   fail_vec,
  output logic [NUM_DUT-1:0] fail_mask
);

  localparam int CNT_W = $clog2(NUM_DUT + 1);
  localparam int WC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = ERR_W + CNT_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state, state_d;
  logic [VEC_W-1:0] vec, vec_d;
  logic [WC_W-1:0] wait_cnt, wait_d;
  logic [ERR_W-1:0] err_d;
  logic pass_d, fv_d;
  logic [VEC_W-1:0] fvec_d;
  logic [NUM_DUT-1:0] fmask_d;

  logic [NUM_DUT-1:0] mask;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0] sum;
  logic [ERR_W-1:0] err_sat;
  logic stop;

  mux_sweep_cmp #(
    .NUM_DUT(NUM_DUT),
    .CNT_W  (CNT_W)
  ) u_cmp (
    .vec    (vec),
    .dut_out(dut_out),
    .mask   (mask),
    .cnt    (cnt)
  );

  assign sel = vec[2];
  assign in0 = vec[1];
  assign in1 = vec[0];
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

  assign sum = SW'(err_count) + SW'(cnt);
  assign err_sat = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];

`ifdef MUX_SWEEP_STOP_ON_ERR_EN
  assign stop = (vec == LAST_VEC) || (mask != '0);
`else
  assign stop = (vec == LAST_VEC);
`endif

  always_comb begin
    state_d = state;
    vec_d   = vec;
    wait_d  = wait_cnt;
    err_d   = err_count;
    pass_d  = pass;
    fv_d    = fail_valid;
    fvec_d  = fail_vec;
    fmask_d = fail_mask;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          wait_d  = WC_W'(SETTLE_CYCLES);
          err_d   = '0;
          pass_d  = 1'b0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          fmask_d = '0;
        end
      end
      SETTLE: begin
        wait_d = wait_cnt - WC_W'(1);
        if (wait_cnt == WC_W'(1)) state_d = CHECK;
      end
      CHECK: begin
        err_d = err_sat;
        if (mask != '0 && !fail_valid) begin
          fv_d    = 1'b1;
          fvec_d  = vec;
          fmask_d = mask;
        end
        // Result is published on entry to DONE so it is valid with done.
        if (stop) begin
          state_d = DONE;
          pass_d  = (err_sat == '0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec + VEC_W'(1);
          wait_d  = WC_W'(SETTLE_CYCLES);
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      wait_cnt   <= '0;
      err_count  <= '0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_mask  <= '0;
    end else begin
      state      <= state_d;
      vec        <= vec_d;
      wait_cnt   <= wait_d;
      err_count  <= err_d;
      pass       <= pass_d;
      fail_valid <= fv_d;
      fail_vec   <= fvec_d;
      fail_mask  <= fmask_d;
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: muxes modelled as 8-entry truth tables.
// Honours MUX_SWEEP_STOP_ON_ERR_EN when compiled with it.
module tb_mux_sweep_checker;

  localparam int ND = 3;
  localparam int SC = 2;
  localparam int EW = 4;
  localparam int EMAX = 15;
  localparam logic [7:0] GOOD = 8'hAC;
  localparam logic [7:0] SWAP = 8'hCA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel, in0, in1;
  logic [ND-1:0] dut_out;
  logic busy, done, pass, fail_valid;
  logic [EW-1:0] err_count;
  logic [2:0] fail_vec;
  logic [ND-1:0] fail_mask;

  logic [7:0] tt [ND];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mux_sweep_checker #(
    .NUM_DUT(ND),
    .SETTLE_CYCLES(SC),
    .ERR_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sel(sel),
    .in0(in0),
    .in1(in1),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_valid(fail_valid),
    .fail_vec(fail_vec),
    .fail_mask(fail_mask)
  );

  always_comb begin
    dut_out = '0;
    for (int d = 0; d < ND; d++)
      dut_out[d] = tt[d][{sel, in0, in1}];
  end

  typedef struct {
    logic [7:0] t0, t1, t2;
    int done_c;
    int err;
    bit fv;
    logic [2:0] fvec;
    logic [2:0] mask;
  } rec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the vectors with plain loops over the truth tables.
  task automatic model(output int done_c, output int err, output bit fv,
                       output logic [2:0] fvec, output logic [2:0] fmask);
    int nv;
    logic [2:0] m;
    logic [2:0] v3;
    bit e;
    err = 0; fv = 0; fvec = 0; fmask = 0; nv = 0;
    for (int v = 0; v < 8; v++) begin
      v3 = v[2:0];
      e = v3[2] ? v3[0] : v3[1];
      m = 0;
      for (int d = 0; d < ND; d++)
        m[d] = (tt[d][v] != e);
      err += $countones(m);
      nv = v + 1;
      if (m != 0 && !fv) begin
        fv = 1; fvec = v3; fmask = m;
      end
`ifdef MUX_SWEEP_STOP_ON_ERR_EN
      if (m != 0) break;
`endif
    end
    if (err > EMAX) err = EMAX;
    done_c = nv * (SC + 1) + 1;
  endtask

  task automatic run_sweep(input string nm, input int exp_done,
                           input int exp_err, input bit exp_fv,
                           input logic [2:0] exp_fvec,
                           input logic [2:0] exp_mask, input bit repulse);
    int ev;
    int ndone;
    logic [2:0] ev3;
    ndone = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, ".clr"}, {err_count, pass, fail_valid}, 0);
    for (int c = 1; c <= exp_done + 1; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (done) ndone++;
      start = repulse && (c == 5 || c == exp_done);
      if (c < exp_done) begin
        ev = (c - 1) / (SC + 1);
        ev3 = ev[2:0];
        chk($sformatf("%s.walk%0d", nm, c), {sel, in0, in1, busy, done},
            {ev3, 1'b1, 1'b0});
      end else if (c == exp_done) begin
        chk({nm, ".done"}, {busy, done}, 2'b01);
        chk({nm, ".err"}, err_count, exp_err);
        chk({nm, ".pass"}, pass, exp_err == 0);
        chk({nm, ".fv"}, fail_valid, exp_fv);
        chk({nm, ".fvec"}, fail_vec, exp_fvec);
        chk({nm, ".fmask"}, fail_mask, exp_mask);
      end else begin
        chk({nm, ".idle"}, {sel, in0, in1, busy, done}, 0);
        chk({nm, ".hold"}, {err_count, pass}, {exp_err[EW-1:0], exp_err == 0});
      end
    end
    start = 1'b0;
    chk({nm, ".ndone"}, ndone, 1);
  endtask

  rec_t tab [6];

  initial begin
    int dc, er;
    bit fv;
    logic [2:0] fvec, fm;
    bit hit;

    tab[0] = '{GOOD, GOOD, GOOD, 25, 0, 0, 3'b000, 3'b000};
`ifdef MUX_SWEEP_STOP_ON_ERR_EN
    tab[1] = '{GOOD, 8'h00, GOOD, 10, 1, 1, 3'b010, 3'b010};
    tab[2] = '{GOOD, GOOD, SWAP, 7, 1, 1, 3'b001, 3'b100};
    tab[3] = '{8'hFF, 8'hFF, 8'hFF, 4, 3, 1, 3'b000, 3'b111};
    tab[4] = '{~GOOD, ~GOOD, ~GOOD, 4, 3, 1, 3'b000, 3'b111};
    tab[5] = '{8'hFF, GOOD, GOOD, 4, 1, 1, 3'b000, 3'b001};
`else
    tab[1] = '{GOOD, 8'h00, GOOD, 25, 4, 1, 3'b010, 3'b010};
    tab[2] = '{GOOD, GOOD, SWAP, 25, 4, 1, 3'b001, 3'b100};
    tab[3] = '{8'hFF, 8'hFF, 8'hFF, 25, 12, 1, 3'b000, 3'b111};
    tab[4] = '{~GOOD, ~GOOD, ~GOOD, 25, 15, 1, 3'b000, 3'b111};
    tab[5] = '{8'hFF, GOOD, GOOD, 25, 4, 1, 3'b000, 3'b001};
`endif

    for (int d = 0; d < ND; d++) tt[d] = GOOD;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", {sel, in0, in1, busy, done, pass, err_count,
                  fail_valid, fail_vec, fail_mask}, 0);

    for (int i = 0; i < 6; i++) begin
      tt[0] = tab[i].t0; tt[1] = tab[i].t1; tt[2] = tab[i].t2;
      run_sweep($sformatf("tab%0d", i), tab[i].done_c, tab[i].err,
                tab[i].fv, tab[i].fvec, tab[i].mask, i == 2);
    end

    // Reset in the middle of a sweep.
    tt[0] = GOOD; tt[2] = GOOD;
`ifdef MUX_SWEEP_STOP_ON_ERR_EN
    tt[1] = GOOD;
`else
    tt[1] = 8'h00;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if ({sel, in0, in1} == 3'b100) hit = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rst.reach100", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.state", {sel, in0, in1, busy, done, pass, err_count,
                      fail_valid, fail_vec, fail_mask}, 0);
    tt[1] = GOOD;
    run_sweep("after_rst", 25, 0, 0, 3'b000, 3'b000, 1);

    // Random truth tables against the model.
    for (int i = 0; i < 25; i++) begin
      for (int d = 0; d < ND; d++)
        tt[d] = ($urandom_range(0, 1) == 1) ? GOOD :
                GOOD ^ 8'($urandom & $urandom);
      model(dc, er, fv, fvec, fm);
      run_sweep($sformatf("rnd%0d", i), dc, er, fv, fvec, fm,
                $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
